pc_sequencer: RTL and testbench
===============================

// Module: pc_sequencer
// PURPOSE
//  Owns the program counter and sequences next-PC selection for the MIPS fetch stage.
//  Forms J-type targets as {PC+4[31:28], instr_index, 2'b00}, branch targets as PC+4 + sext(offset)<<2,
//  and JR targets from a register. Presents the PC to IF over a valid/ready handshake.
//  Accepts control-flow decisions from decode over a second valid/ready handshake.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded by reset; must be word-aligned
// PORTS
//  clk             in   1   clock, rising edge
//  rst_n           in   1   async reset, active low
//  pc_out          out  32  current fetch address
//  pc_valid        out  1   pc_out is valid for IF
//  fetch_ready     in   1   IF accepts pc_out (fetch fires when pc_valid & fetch_ready)
//  ctrl_valid      in   1   decode presents a control-flow decision
//  ctrl_ready      out  1   sequencer can accept a decision
//  ctrl_op         in   2   00 none, 01 J/JAL, 10 branch, 11 JR
//  ctrl_pc         in   32  PC of the control-flow instruction
//  instr_index     in   26  J-type index field
//  br_offset       in   16  branch immediate, two's complement words
//  br_taken        in   1   branch condition result; ignored unless ctrl_op=10
//  jr_target       in   32  register value for JR
//  addr_err        out  1   level; JR target misaligned, sequencer halted
//  redirect_count  out  16  number of taken redirects, saturating
// BEHAVIOUR
//  Reset (async, any state): pc_out=RESET_PC, pc_valid=0, ctrl_ready=0, addr_err=0, redirect_count=0, state=BOOT.
//  States: BOOT -> RUN on the first clock after rst_n rises; RUN; SLOT (macro only); ERR (sticky until reset).
//  BOOT: pc_valid=0, ctrl_ready=0.
//  RUN: pc_valid=1, ctrl_ready=1. Decision accepted when ctrl_valid & ctrl_ready.
//  Taken redirect = accepted with op=01, op=11, or op=10 & br_taken. op=00 or untaken branch: consumed, no PC effect.
//  Targets, mod 2^32:
//    seq = pc_out + 4 (FFFF_FFFC wraps to 0000_0000); base = ctrl_pc + 4.
//    J = {base[31:28], instr_index, 2'b00}; branch = base + {{14{br_offset[15]}}, br_offset, 2'b00}; JR = jr_target.
//  Next-PC priority in RUN: taken redirect > fetch fire (seq) > hold.
//  Redirect coinciding with fetch fire: redirect wins, seq discarded. Latency: target on pc_out the cycle after acceptance.
//  JR with jr_target[1:0]!=0: no PC update; next cycle ERR. ERR: addr_err=1, pc_valid=0, ctrl_ready=0, pc_out holds.
//  redirect_count increments by 1 per taken redirect; holds at 16'hFFFF. Error JR does not count.
//  pc_out holds while pc_valid & !fetch_ready and no redirect is taken.
// CONFIGURATION
//  BRANCH_DELAY_SLOT_EN defined: taken redirect latches target into target_q, sets pc_out=base (delay slot),
//    goes to SLOT. SLOT: pc_valid=1, ctrl_ready=0. On fetch fire: pc_out=target_q, state RUN.
//    Reset in SLOT discards target_q.
//  BRANCH_DELAY_SLOT_EN undefined: no SLOT state, no target_q; redirects apply directly as above.
// TESTING
//  rst_n low, then released; fetch_ready=1 -> pc_out 0,0,4,8 with pc_valid 0,1,1,1; addr_err=0
//  pc_out=0x0040_0010; J, ctrl_pc=0x0040_000C, instr_index=0x010_0040 -> pc_out=0x0040_0100 next cycle; redirect_count=1
//  Branch ctrl_pc=0x100, br_offset=16'hFFFF, taken -> 0x100; same with br_taken=0 -> seq advance, count unchanged
//  JR jr_target=0x0000_2002 -> addr_err=1, pc_valid=0, ctrl_ready=0 held until rst_n; then pc_out=RESET_PC
//  pc_out=0xFFFF_FFFC, fetch fire -> 0x0000_0000; fetch_ready=0 for 3 cycles -> pc_out stable
//  Delay slot (macro on): J at ctrl_pc=0x20 to 0x80 -> pc_out 0x24, held until fetch fire, then 0x80; ctrl_ready=0 while in SLOT

Source files
------------

// File: rtl/pc_sequencer.sv
// Purpose: owns the fetch PC and selects between sequential, J, branch and JR next-PC sources.
// Latency: an accepted redirect appears on pc_out the following cycle; sequential advance one cycle after a fetch fire.
// Backpressure: pc_out holds while IF stalls (fetch_ready=0); ctrl_ready drops outside RUN so decode must hold its decision.
//
// Ports: clk/rst_n (async active-low); pc_out/pc_valid/fetch_ready to IF;
//        ctrl_valid/ctrl_ready/ctrl_op/ctrl_pc/instr_index/br_offset/br_taken/jr_target from decode;
//        addr_err (sticky misaligned-JR halt), redirect_count (saturating count of taken redirects).
// Optional feature: define BRANCH_DELAY_SLOT_EN to fetch the architectural delay slot before the redirect target.
module pc_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] pc_out,
    output logic        pc_valid,
    input  logic        fetch_ready,
    input  logic        ctrl_valid,
    output logic        ctrl_ready,
    input  logic [1:0]  ctrl_op,
    input  logic [31:0] ctrl_pc,
    input  logic [25:0] instr_index,
    input  logic [15:0] br_offset,
    input  logic        br_taken,
    input  logic [31:0] jr_target,
    output logic        addr_err,
    output logic [15:0] redirect_count
);

    localparam logic [1:0] OP_NONE = 2'b00;
    localparam logic [1:0] OP_J    = 2'b01;
    localparam logic [1:0] OP_BR   = 2'b10;
    localparam logic [1:0] OP_JR   = 2'b11;

`ifdef BRANCH_DELAY_SLOT_EN
    typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_SLOT = 2'd2, S_ERR = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_BOOT = 2'd0, S_RUN = 2'd1, S_ERR = 2'd3} state_t;
`endif

    state_t      state_q, state_n;
    logic [31:0] pc_q, pc_n;
    logic [15:0] cnt_q, cnt_n;
    logic [31:0] base, seq, target;
    logic        fire, accept, taken, jr_bad, redirect;

`ifdef BRANCH_DELAY_SLOT_EN
    logic [31:0] target_q, target_n;
`endif

    // Handshake outputs are pure functions of state, so they are glitch-free registered-state decodes.
    assign pc_valid       = (state_q == S_RUN)
`ifdef BRANCH_DELAY_SLOT_EN
                          | (state_q == S_SLOT)
`endif
                          ;
    assign ctrl_ready     = (state_q == S_RUN);
    assign addr_err       = (state_q == S_ERR);
    assign pc_out         = pc_q;
    assign redirect_count = cnt_q;

    assign fire   = pc_valid & fetch_ready;
    assign accept = ctrl_valid & ctrl_ready;
    assign seq    = pc_q + 32'd4;
    assign base   = ctrl_pc + 32'd4;

    always_comb begin
        target = seq;
        taken  = 1'b0;
        case (ctrl_op)
            OP_NONE: begin
                target = seq;
                taken  = 1'b0;
            end
            OP_J: begin
                target = {base[31:28], instr_index, 2'b00};
                taken  = 1'b1;
            end
            OP_BR: begin
                target = base + {{14{br_offset[15]}}, br_offset, 2'b00};
                taken  = br_taken;
            end
            OP_JR: begin
                target = jr_target;
                taken  = 1'b1;
            end
            default: begin
                target = seq;
                taken  = 1'b0;
            end
        endcase
    end

    // A misaligned JR halts the sequencer instead of redirecting, and is not counted.
    assign jr_bad   = accept & (ctrl_op == OP_JR) & (jr_target[1:0] != 2'b00);
    assign redirect = accept & taken & ~jr_bad;

    always_comb begin
        state_n = state_q;
        pc_n    = pc_q;
        cnt_n   = cnt_q;
`ifdef BRANCH_DELAY_SLOT_EN
        target_n = target_q;
`endif
        case (state_q)
            S_BOOT: state_n = S_RUN;
            S_RUN: begin
                if (jr_bad) begin
                    state_n = S_ERR;
                end else if (redirect) begin
                    if (cnt_q != 16'hFFFF) cnt_n = cnt_q + 16'd1;
`ifdef BRANCH_DELAY_SLOT_EN
                    // Fetch the delay slot first; the real target waits in target_q.
                    pc_n     = base;
                    target_n = target;
                    state_n  = S_SLOT;
`else
                    pc_n     = target;
`endif
                end else if (fire) begin
                    pc_n = seq;
                end
            end
`ifdef BRANCH_DELAY_SLOT_EN
            S_SLOT: begin
                if (fire) begin
                    pc_n    = target_q;
                    state_n = S_RUN;
                end
            end
`endif
            S_ERR: state_n = S_ERR;
            default: state_n = S_ERR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_n;
            pc_q    <= pc_n;
            cnt_q   <= cnt_n;
        end
    end

`ifdef BRANCH_DELAY_SLOT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) target_q <= 32'd0;
        else        target_q <= target_n;
    end
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Purpose: directed self-checking bench for pc_sequencer with a scoreboard of expected post-edge states.
// Latency: each step drives inputs, advances one clock edge and compares the DUT against the queued expectation.
// Backpressure: exercises fetch_ready stalls, redirects during stalls and the sticky error halt.
module tb_pc_sequencer;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_out;
    logic        pc_valid;
    logic        fetch_ready;
    logic        ctrl_valid;
    logic        ctrl_ready;
    logic [1:0]  ctrl_op;
    logic [31:0] ctrl_pc;
    logic [25:0] instr_index;
    logic [15:0] br_offset;
    logic        br_taken;
    logic [31:0] jr_target;
    logic        addr_err;
    logic [15:0] redirect_count;

    pc_sequencer #(.RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n), .pc_out(pc_out), .pc_valid(pc_valid),
        .fetch_ready(fetch_ready), .ctrl_valid(ctrl_valid), .ctrl_ready(ctrl_ready),
        .ctrl_op(ctrl_op), .ctrl_pc(ctrl_pc), .instr_index(instr_index),
        .br_offset(br_offset), .br_taken(br_taken), .jr_target(jr_target),
        .addr_err(addr_err), .redirect_count(redirect_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [31:0] pc;
        logic        vld;
        logic        rdy;
        logic        err;
        logic [15:0] cnt;
    } exp_t;

    exp_t        sb[$];
    int          n_assert = 0;
    int          n_fail   = 0;
    logic [15:0] mcnt     = 16'd0;
    logic [31:0] mpc      = RST_PC;

    task automatic push(input string tag, input logic [31:0] pc, input logic vld,
                        input logic rdy, input logic err);
        exp_t e;
        e.tag = tag; e.pc = pc; e.vld = vld; e.rdy = rdy; e.err = err; e.cnt = mcnt;
        sb.push_back(e);
        mpc = pc;
    endtask

    task automatic check();
        exp_t e;
        if (sb.size() == 0) begin
            n_assert++; n_fail++;
            $display("FAIL scoreboard_empty got 0 entries required 1");
            return;
        end
        e = sb.pop_front();
        n_assert++;
        assert (pc_out === e.pc) else begin
            n_fail++; $error("FAIL %s pc_out got %h required %h", e.tag, pc_out, e.pc);
        end
        n_assert++;
        assert (pc_valid === e.vld) else begin
            n_fail++; $error("FAIL %s pc_valid got %b required %b", e.tag, pc_valid, e.vld);
        end
        n_assert++;
        assert (ctrl_ready === e.rdy) else begin
            n_fail++; $error("FAIL %s ctrl_ready got %b required %b", e.tag, ctrl_ready, e.rdy);
        end
        n_assert++;
        assert (addr_err === e.err) else begin
            n_fail++; $error("FAIL %s addr_err got %b required %b", e.tag, addr_err, e.err);
        end
        n_assert++;
        assert (redirect_count === e.cnt) else begin
            n_fail++; $error("FAIL %s redirect_count got %h required %h", e.tag, redirect_count, e.cnt);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        check();
    endtask

    // Drive one decode decision for a single cycle; exp_pc is the resulting fetch target.
    task automatic ctrl_step(input string tag, input logic [1:0] op, input logic [31:0] cpc,
                             input logic [25:0] idx, input logic [15:0] off, input logic tk,
                             input logic [31:0] jrt, input logic [31:0] exp_pc, input logic tkn);
        ctrl_valid = 1'b1; ctrl_op = op; ctrl_pc = cpc; instr_index = idx;
        br_offset = off; br_taken = tk; jr_target = jrt;
        if (tkn) mcnt = mcnt + 16'd1;
`ifdef BRANCH_DELAY_SLOT_EN
        if (tkn) begin
            push({tag, "_slot"}, cpc + 32'd4, 1'b1, 1'b0, 1'b0);
            step();
            ctrl_valid = 1'b0;
            fetch_ready = 1'b1;
        end
`endif
        push(tag, exp_pc, 1'b1, 1'b1, 1'b0);
        step();
        ctrl_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout got running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; fetch_ready = 1'b0; ctrl_valid = 1'b0; ctrl_op = 2'b00;
        ctrl_pc = 32'd0; instr_index = 26'd0; br_offset = 16'd0; br_taken = 1'b0;
        jr_target = 32'd0;
        #12;
        push("reset", RST_PC, 1'b0, 1'b0, 1'b0);
        check();

        // Boot: pc 0,0,4,8 with valid 0,1,1,1
        rst_n = 1'b1; fetch_ready = 1'b1;
        push("boot", RST_PC, 1'b1, 1'b1, 1'b0);        step();
        push("seq4", 32'h4, 1'b1, 1'b1, 1'b0);         step();
        push("seq8", 32'h8, 1'b1, 1'b1, 1'b0);         step();

        // Redirects coinciding with fetch fire
        ctrl_step("jr_go", 2'b11, 32'h0, 26'h0, 16'h0, 1'b0, 32'h0040_0010, 32'h0040_0010, 1'b1);
        ctrl_step("j_low", 2'b01, 32'h0040_000C, 26'h010_0040, 16'h0, 1'b0, 32'h0, 32'h0040_0100, 1'b1);
        ctrl_step("br_back", 2'b10, 32'h100, 26'h0, 16'hFFFF, 1'b1, 32'h0, 32'h0000_0100, 1'b1);
        ctrl_step("br_nt", 2'b10, 32'h100, 26'h0, 16'hFFFF, 1'b0, 32'h0, mpc + 32'd4, 1'b0);
        ctrl_step("op_none", 2'b00, 32'h500, 26'h3FF_FFFF, 16'h7FFF, 1'b1, 32'h4, mpc + 32'd4, 1'b0);
        ctrl_step("br_fwd", 2'b10, 32'h1000, 26'h0, 16'h0010, 1'b1, 32'h0, 32'h0000_1044, 1'b1);
        ctrl_step("j_high", 2'b01, 32'hA000_0000, 26'h3FF_FFFF, 16'h0, 1'b0, 32'h0, 32'hAFFF_FFFC, 1'b1);

        // IF stall: pc holds for three cycles, then a redirect still wins during the stall
        fetch_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("stall_hold", mpc, 1'b1, 1'b1, 1'b0);
            step();
        end
        ctrl_step("jr_stall", 2'b11, 32'h0, 26'h0, 16'h0, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b1);
`ifndef BRANCH_DELAY_SLOT_EN
        push("stall_after_jr", 32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0); step();
`endif
        fetch_ready = 1'b1;
        push("wrap", 32'h0000_0000, 1'b1, 1'b1, 1'b0); step();
        push("after_wrap", 32'h0000_0004, 1'b1, 1'b1, 1'b0); step();

`ifdef BRANCH_DELAY_SLOT_EN
        // Delay slot held while IF stalls, ctrl_ready low throughout SLOT
        ctrl_valid = 1'b1; ctrl_op = 2'b01; ctrl_pc = 32'h20; instr_index = 26'h20;
        mcnt = mcnt + 16'd1;
        push("slot_enter", 32'h24, 1'b1, 1'b0, 1'b0); step();
        fetch_ready = 1'b0;
        push("slot_hold1", 32'h24, 1'b1, 1'b0, 1'b0); step();
        push("slot_hold2", 32'h24, 1'b1, 1'b0, 1'b0); step();
        ctrl_valid = 1'b0; fetch_ready = 1'b1;
        push("slot_exit", 32'h80, 1'b1, 1'b1, 1'b0); step();
`endif

        // Misaligned JR: halt, no count, pc holds, sticky until reset
        ctrl_valid = 1'b1; ctrl_op = 2'b11; jr_target = 32'h0000_2002;
        push("jr_bad", mpc, 1'b0, 1'b0, 1'b1); step();
        ctrl_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            push("err_hold", mpc, 1'b0, 1'b0, 1'b1);
            step();
        end

        rst_n = 1'b0;
        #2;
        mcnt = 16'd0;
        push("reset2", RST_PC, 1'b0, 1'b0, 1'b0);
        check();
        rst_n = 1'b1;
        push("reboot", RST_PC, 1'b1, 1'b1, 1'b0); step();
        push("reboot_seq", RST_PC + 32'd4, 1'b1, 1'b1, 1'b0); step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
